bus_dev_port: RTL and testbench
===============================

Name: bus_dev_port

Overview:
- Per-device endpoint RTL that sits on one driver slot of the bs_gnrtr_n_rbtr bus.
- Transmit side: buffers host packets in a FWFT FIFO and offers them to the bus arbiter via pndng/D_pop/pop.
- Receive side: captures bus deliveries (push/D_push), filters them on the destination field, and buffers accepted packets for the host.
- Replaces the behavioural bench driver with synthesizable logic, one instance per device.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1 -: 8] are the destination ID.
- depth, 8, entries per FIFO (power of 2, >=2).
- dev_id, 0, this device's 8-bit ID.
- broadcast, 8'hFF, destination ID accepted by every device.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  pckg_sz  host packet to send.
- tx_push  in  1  host write strobe.
- tx_full  out  1  TX FIFO full.
- pndng  out  1  TX FIFO non-empty (to bus).
- D_pop  out  pckg_sz  TX head packet (to bus).
- pop  in  1  bus consumes head.
- push  in  1  bus delivers packet.
- D_push  in  pckg_sz  delivered packet.
- rx_data  out  pckg_sz  RX head packet.
- rx_valid  out  1  RX FIFO non-empty.
- rx_pop  in  1  host consumes RX head.
- tx_count  out  $clog2(depth)+1  TX occupancy.
- rx_count  out  $clog2(depth)+1  RX occupancy.
- err_flags  out  4  sticky: [0] tx overflow, [1] tx underflow (pop while empty), [2] rx overflow, [3] rx underflow.
- misroute_cnt  out  8  count of deliveries whose destination is neither dev_id nor broadcast; saturates at 255.

Behaviour:
- All state is updated on posedge clk. Reset is synchronous, active-high, and overrides every other input in the same cycle.
- On reset: both FIFOs empty; pointers 0; pndng=0, rx_valid=0, tx_full=0; counts 0; err_flags 0; misroute_cnt 0. D_pop/rx_data are don't-care while empty; the implementation drives 0.
- FIFOs are first-word fall-through: D_pop = TX head and rx_data = RX head, combinationally from storage.
- pndng = (tx_count!=0); rx_valid = (rx_count!=0); tx_full = (tx_count==depth).
- TX write: tx_push && !tx_full stores tx_data at wptr. Latency push-to-pndng is 1 cycle when the FIFO was empty.
- TX read: pop && pndng advances rptr. The next head appears on D_pop the following cycle.
- Simultaneous tx_push and pop when full: the pop frees a slot, so the push is accepted and the count is unchanged. This is not an overflow.
- Simultaneous push and pop when empty: the push is stored, the pop is ignored, and err[1] is set.
- Overflow (push when full with no same-cycle pop): the data is dropped, err[0] is set, and the FIFO is unchanged.
- RX accept: on push, let dst = D_push[pckg_sz-1 -: 8]. If dst==dev_id or dst==broadcast, write the packet to the RX FIFO (same full/overflow rules; rx_pop in the same cycle frees a slot). Otherwise drop it and increment misroute_cnt (saturating).
- RX read: rx_pop && rx_valid advances. rx_pop while empty sets err[3] only.
- Pointers are $clog2(depth) bits and wrap naturally. Counts are tracked separately: +1 on write-only, -1 on read-only, unchanged on both.
- Reset mid-operation flushes both FIFOs. Stored packets are lost and no error flags are set.
- err_flags clear only on reset.

Decomposition:
- Package bus_dev_pkg holds:
  - constant ID_W=8;
  - function dest_of(pkt) that extracts the destination field;
  - typedef of the err_flags bit positions (ERR_TX_OVF, ERR_TX_UNF, ERR_RX_OVF, ERR_RX_UNF).
- Sub-module fwft_fifo (params width, depth):
  - ports: clk, reset, wr, wdata, rd, rdata, count, empty, full, ovf, unf;
  - instantiated twice (TX and RX).
- The top level adds the destination filter, the misroute counter, and the sticky error flags.

Test Plan:
- Reset: drive traffic, then reset=1 for 2 cycles -> pndng=0, rx_valid=0, counts=0, err_flags=4'h0, misroute_cnt=0.
- TX order: push 0x01AA, 0x02BB, 0x03CC on consecutive cycles -> pndng rises 1 cycle after the first push. Assert pop each cycle -> D_pop sequence 0x01AA, 0x02BB, 0x03CC, then pndng=0.
- TX full boundary (depth=8): push 8 words -> tx_full=1. A 9th push alone -> err[0]=1, data dropped. Push plus pop together while full -> accepted, tx_count stays 8.
- RX filter (dev_id=2): deliver 0x02AB, 0x03CD, 0xFF11 -> rx_data yields 0x02AB then 0xFF11, misroute_cnt=1, rx_count=2 before any rx_pop.
- Underflow: pop with TX empty and rx_pop with RX empty -> err_flags=4'b1010, FIFOs unchanged. Misroute saturation: 300 misrouted pushes -> misroute_cnt=255.
- Reset mid-operation: with 5 TX and 3 RX entries, assert reset for 1 cycle concurrently with tx_push and push -> both FIFOs empty next cycle and the new data is not stored.

Source files
------------

// File: rtl/bus_dev_pkg.sv
// Shared definitions for the bus device endpoint:
// destination-field width, destination extractor and error-flag bit positions.
package bus_dev_pkg;

    localparam int ID_W    = 8;
    localparam int PKT_MAX = 64;

    typedef enum int unsigned {
        ERR_TX_OVF = 0,
        ERR_TX_UNF = 1,
        ERR_RX_OVF = 2,
        ERR_RX_UNF = 3
    } err_bit_e;

    // Destination ID is the top ID_W bits of a packet of width sz.
    // The packet is passed zero-extended to PKT_MAX bits.
    function automatic logic [ID_W-1:0] dest_of(
        input logic [PKT_MAX-1:0] pkt,
        input int unsigned        sz
    );
        return ID_W'(pkt >> (sz - ID_W));
    endfunction

endpackage

// File: rtl/bus_dev_port_fifo.sv
// First-word fall-through FIFO with separate occupancy count.
// Ports: clk, reset (sync, active-high), wr/wdata write side, rd/rdata
// read side (rdata is the head, 0 when empty), count, empty, full, and
// single-cycle ovf (write dropped) / unf (read while empty) strobes.
module fwft_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [width-1:0]         wdata,
    input  logic                     rd,
    output logic [width-1:0]         rdata,
    output logic [$clog2(depth):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf,
    output logic                     unf
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             do_wr;
    logic             do_rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(depth));
    assign count = cnt;

    // A same-cycle read frees a slot, so a write while full still lands.
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);
    assign ovf   = wr && !do_wr;
    assign unf   = rd && empty;

    assign rdata = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_wr)
                wptr <= wptr + 1'b1;
            if (do_rd)
                rptr <= rptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; reset only blocks a write in that cycle.
    always_ff @(posedge clk) begin
        if (!reset && do_wr)
            mem[wptr] <= wdata;
    end

endmodule

// File: rtl/bus_dev_port.sv
// Per-device bus endpoint: TX FIFO offered to the arbiter (pndng/D_pop/pop),
// RX FIFO fed by destination-filtered bus deliveries (push/D_push).
// Ports: clk, reset; host TX tx_data/tx_push/tx_full; bus pndng/D_pop/pop,
// push/D_push; host RX rx_data/rx_valid/rx_pop; status tx_count, rx_count,
// sticky err_flags and saturating misroute_cnt.
module bus_dev_port
    import bus_dev_pkg::*;
#(
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] dev_id    = 8'h00,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [pckg_sz-1:0]     tx_data,
    input  logic                   tx_push,
    output logic                   tx_full,
    output logic                   pndng,
    output logic [pckg_sz-1:0]     D_pop,
    input  logic                   pop,
    input  logic                   push,
    input  logic [pckg_sz-1:0]     D_push,
    output logic [pckg_sz-1:0]     rx_data,
    output logic                   rx_valid,
    input  logic                   rx_pop,
    output logic [$clog2(depth):0] tx_count,
    output logic [$clog2(depth):0] rx_count,
    output logic [3:0]             err_flags,
    output logic [7:0]             misroute_cnt
);

    logic            tx_empty;
    logic            tx_ovf;
    logic            tx_unf;
    logic            rx_empty;
    logic            rx_full;
    logic            rx_ovf;
    logic            rx_unf;
    logic            rx_wr;
    logic            hit;
    logic [ID_W-1:0] dst;

    assign dst   = dest_of(PKT_MAX'(D_push), pckg_sz);
    assign hit   = (dst == dev_id) || (dst == broadcast);
    assign rx_wr = push && hit;

    fwft_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_push),
        .wdata (tx_data),
        .rd    (pop),
        .rdata (D_pop),
        .count (tx_count),
        .empty (tx_empty),
        .full  (tx_full),
        .ovf   (tx_ovf),
        .unf   (tx_unf)
    );

    fwft_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_rx (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_wr),
        .wdata (D_push),
        .rd    (rx_pop),
        .rdata (rx_data),
        .count (rx_count),
        .empty (rx_empty),
        .full  (rx_full),
        .ovf   (rx_ovf),
        .unf   (rx_unf)
    );

    assign pndng    = !tx_empty;
    assign rx_valid = !rx_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_flags <= '0;
        end else begin
            if (tx_ovf)
                err_flags[ERR_TX_OVF] <= 1'b1;
            if (tx_unf)
                err_flags[ERR_TX_UNF] <= 1'b1;
            if (rx_ovf)
                err_flags[ERR_RX_OVF] <= 1'b1;
            if (rx_unf)
                err_flags[ERR_RX_UNF] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            misroute_cnt <= '0;
        else if (push && !hit && misroute_cnt != 8'hFF)
            misroute_cnt <= misroute_cnt + 8'd1;
    end

endmodule

// File: tb/tb_bus_dev_port.sv
// Scoreboard bench for bus_dev_port: stimulus pushes expected packets into
// queues, a negedge monitor pops/compares on every bus or host handshake.
module tb_bus_dev_port;

    localparam int         DEPTH = 8;
    localparam logic [7:0] DEV   = 8'h02;

    logic        clk;
    logic        reset;
    logic [15:0] tx_data;
    logic        tx_push;
    logic        tx_full;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic [3:0]  tx_count;
    logic [3:0]  rx_count;
    logic [3:0]  err_flags;
    logic [7:0]  misroute_cnt;

    bus_dev_port #(
        .pckg_sz   (16),
        .depth     (DEPTH),
        .dev_id    (DEV),
        .broadcast (8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_push      (tx_push),
        .tx_full      (tx_full),
        .pndng        (pndng),
        .D_pop        (D_pop),
        .pop          (pop),
        .push         (push),
        .D_push       (D_push),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_pop       (rx_pop),
        .tx_count     (tx_count),
        .rx_count     (rx_count),
        .err_flags    (err_flags),
        .misroute_cnt (misroute_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue contents, sticky errors, misroute count.
    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    logic [3:0]  m_err = 4'h0;
    int          m_mis = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endfunction

    // Monitor: state compare, then handshake scoreboard pops.
    always @(negedge clk) begin
        chk("pndng", 32'(pndng), 32'(txq.size() != 0));
        chk("tx_full", 32'(tx_full), 32'(txq.size() == DEPTH));
        chk("tx_count", 32'(tx_count), 32'(txq.size()));
        chk("rx_valid", 32'(rx_valid), 32'(rxq.size() != 0));
        chk("rx_count", 32'(rx_count), 32'(rxq.size()));
        chk("err_flags", 32'(err_flags), 32'(m_err));
        chk("misroute", 32'(misroute_cnt), 32'(m_mis));
        if (!reset && pop && pndng) begin
            if (txq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL d_pop: got %0h expected none", D_pop);
            end else begin
                chk("d_pop", 32'(D_pop), 32'(txq.pop_front()));
            end
        end
        if (!reset && rx_pop && rx_valid) begin
            if (rxq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_data: got %0h expected none", rx_data);
            end else begin
                chk("rx_data", 32'(rx_data), 32'(rxq.pop_front()));
            end
        end
    end

    task automatic drive(input bit r, input bit tp, input logic [15:0] td,
                         input bit p, input bit ps, input logic [15:0] dp,
                         input bit rp);
        int txn;
        int rxn;
        bit hit;
        @(posedge clk);
        #1;
        reset   = r;
        tx_push = tp;
        tx_data = td;
        pop     = p;
        push    = ps;
        D_push  = dp;
        rx_pop  = rp;
        txn = txq.size();
        rxn = rxq.size();
        hit = (dp[15:8] == DEV) || (dp[15:8] == 8'hFF);
        @(negedge clk);
        #1;
        if (r) begin
            txq.delete();
            rxq.delete();
            m_err = 4'h0;
            m_mis = 0;
        end else begin
            if (tp && (txn < DEPTH || (p && txn > 0)))
                txq.push_back(td);
            if (tp && txn == DEPTH && !p)
                m_err[0] = 1'b1;
            if (p && txn == 0)
                m_err[1] = 1'b1;
            if (ps && hit) begin
                if (rxn < DEPTH || (rp && rxn > 0))
                    rxq.push_back(dp);
                else
                    m_err[2] = 1'b1;
            end
            if (ps && !hit && m_mis < 255)
                m_mis++;
            if (rp && rxn == 0)
                m_err[3] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 16'h0, 0, 0, 16'h0, 0);
    endtask

    task automatic rst(input int n);
        for (int i = 0; i < n; i++)
            drive(1, 0, 16'h0, 0, 0, 16'h0, 0);
    endtask

    initial begin
        reset   = 1'b1;
        tx_push = 1'b0;
        tx_data = '0;
        pop     = 1'b0;
        push    = 1'b0;
        D_push  = '0;
        rx_pop  = 1'b0;

        // Reset after some traffic.
        rst(1);
        drive(0, 1, 16'h1234, 0, 1, 16'h0255, 0);
        drive(0, 0, 16'h0, 1, 1, 16'h0755, 1);
        rst(2);

        // TX ordering.
        drive(0, 1, 16'h01AA, 0, 0, 16'h0, 0);
        drive(0, 1, 16'h02BB, 0, 0, 16'h0, 0);
        drive(0, 1, 16'h03CC, 0, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++)
            drive(0, 0, 16'h0, 1, 0, 16'h0, 0);
        idle(1);

        // TX full boundary, overflow, push+pop while full.
        for (int i = 0; i < DEPTH; i++)
            drive(0, 1, 16'(16'hA000 + i), 0, 0, 16'h0, 0);
        drive(0, 1, 16'hDEAD, 0, 0, 16'h0, 0);
        drive(0, 1, 16'hBEEF, 1, 0, 16'h0, 0);
        for (int i = 0; i < DEPTH; i++)
            drive(0, 0, 16'h0, 1, 0, 16'h0, 0);
        idle(1);
        rst(1);

        // RX destination filter.
        drive(0, 0, 16'h0, 0, 1, 16'h02AB, 0);
        drive(0, 0, 16'h0, 0, 1, 16'h03CD, 0);
        drive(0, 0, 16'h0, 0, 1, 16'hFF11, 0);
        idle(1);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 1);
        drive(0, 0, 16'h0, 0, 0, 16'h0, 1);
        idle(1);
        rst(1);

        // Underflows, then misroute saturation.
        drive(0, 0, 16'h0, 1, 0, 16'h0, 1);
        idle(1);
        for (int i = 0; i < 300; i++)
            drive(0, 0, 16'h0, 0, 1, 16'(16'h0300 + i), 0);
        idle(1);
        rst(1);

        // RX overflow, with same-cycle rx_pop rescue.
        for (int i = 0; i < DEPTH + 1; i++)
            drive(0, 0, 16'h0, 0, 1, 16'(16'h0240 + i), 0);
        drive(0, 0, 16'h0, 0, 1, 16'hFF77, 1);
        idle(1);
        rst(1);

        // Reset mid-operation with concurrent writes.
        for (int i = 0; i < 5; i++)
            drive(0, 1, 16'(16'h5500 + i), 0, i < 3, 16'(16'h0260 + i), 0);
        drive(1, 1, 16'h7777, 0, 1, 16'h0288, 0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] d;
            int sel;
            sel = $urandom_range(0, 3);
            d   = 16'($urandom);
            if (sel == 0 || sel == 3)
                d[15:8] = DEV;
            else if (sel == 1)
                d[15:8] = 8'hFF;
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 9) < 6, 16'($urandom),
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 1) == 1, d,
                  $urandom_range(0, 9) < 4);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
